aemb_wb_arbiter: RTL and testbench

- Two-master, one-slave Wishbone classic arbiter for the aeMB EDK32 core: shares one memory port between the instruction bus (IWB, read-only) and the data bus (DWB, read/write).
- Sits between the core and a unified instruction/data RAM, replacing separate I/D memory ports.
- Tie arbitration is round-robin. A watchdog terminates transfers the slave never acknowledges.

---
 rtl/aemb_wb_arbiter_pkg.sv | 14 +
 rtl/aemb_wb_wdog.sv | 43 ++++
 rtl/aemb_wb_arbiter.sv | 117 +++++++++++
 tb/tb_aemb_wb_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aemb_wb_arbiter_pkg.sv
// rtl/aemb_wb_arbiter_pkg.sv - shared state encoding and constants for the aeMB Wishbone arbiter
package aemb_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IBUS = 2'd1,
        ST_DBUS = 2'd2
    } arb_state_t;

    // Read data returned to a master whose transfer was cut off by the watchdog.
    localparam logic [31:0] TMO_DATA = 32'h0;
    localparam logic [3:0]  SEL_WORD = 4'hF;

endpackage

// File: rtl/aemb_wb_wdog.sv
// rtl/aemb_wb_wdog.sv - per-grant acknowledge watchdog with sticky bus error flag
module aemb_wb_wdog #(
    parameter int TMO = 255,
    parameter int TW  = 8
) (
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    input  logic grant_start,
    input  logic grant_busy,
    input  logic mem_ack_i,
    input  logic err_clr_i,
    output logic tmo_hit,
    output logic bus_err_o
);

    localparam logic [TW-1:0] CNT_LAST = TW'((TMO == 0) ? 0 : TMO - 1);
    localparam logic [TW-1:0] CNT_MAX  = '1;

    logic [TW-1:0] cnt;

    // A real acknowledge in the final cycle beats the timeout.
    assign tmo_hit = (TMO != 0) && grant_busy && (cnt == CNT_LAST) && !mem_ack_i;

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            cnt       <= '0;
            bus_err_o <= 1'b0;
        end else begin
            if (grant_start) begin
                cnt <= '0;
            end else if (grant_busy && !mem_ack_i && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end

            if (tmo_hit) begin
                bus_err_o <= 1'b1;
            end else if (err_clr_i) begin
                bus_err_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aemb_wb_arbiter.sv
// rtl/aemb_wb_arbiter.sv - round-robin IWB/DWB to single Wishbone slave arbiter
module aemb_wb_arbiter #(
    parameter int AW  = 16,
    parameter int TMO = 255,
    parameter int TW  = 8
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          iwb_stb_i,
    input  logic [AW-1:2] iwb_adr_i,
    output logic          iwb_ack_o,
    output logic [31:0]   iwb_dat_o,
    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [AW-1:2] dwb_adr_i,
    input  logic [31:0]   dwb_dat_i,
    output logic          dwb_ack_o,
    output logic [31:0]   dwb_dat_o,
    output logic          mem_stb_o,
    output logic          mem_wre_o,
    output logic [3:0]    mem_sel_o,
    output logic [AW-1:2] mem_adr_o,
    output logic [31:0]   mem_dat_o,
    input  logic [31:0]   mem_dat_i,
    input  logic          mem_ack_i,
    output logic          bus_err_o,
    input  logic          err_clr_i
);

    import aemb_wb_arbiter_pkg::*;

    arb_state_t  state;
    logic        last_dbus;
    logic        grant_start;
    logic        grant_busy;
    logic        pick_dbus;
    logic        owner_stb;
    logic        xfer_done;
    logic        tmo_hit;
    logic [31:0] rd_dat;

    assign grant_start = (state == ST_IDLE) && (iwb_stb_i || dwb_stb_i);
    assign grant_busy  = (state != ST_IDLE);
    // DWB wins unless IWB also requests and DWB held the previous grant.
    assign pick_dbus   = dwb_stb_i && (!iwb_stb_i || !last_dbus);
    assign owner_stb   = (state == ST_IBUS) ? iwb_stb_i : dwb_stb_i;
    assign xfer_done   = mem_ack_i || tmo_hit || !owner_stb;

    assign iwb_ack_o = (state == ST_IBUS) && (mem_ack_i || tmo_hit);
    assign dwb_ack_o = (state == ST_DBUS) && (mem_ack_i || tmo_hit);

    // Gated by reset too, so every output reads zero while reset is held.
    assign rd_dat    = (!sys_rst_i || tmo_hit) ? TMO_DATA : mem_dat_i;
    assign iwb_dat_o = rd_dat;
    assign dwb_dat_o = rd_dat;

    aemb_wb_wdog #(
        .TMO (TMO),
        .TW  (TW)
    ) u_wdog (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_i   (sys_rst_i),
        .grant_start (grant_start),
        .grant_busy  (grant_busy),
        .mem_ack_i   (mem_ack_i),
        .err_clr_i   (err_clr_i),
        .tmo_hit     (tmo_hit),
        .bus_err_o   (bus_err_o)
    );

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state     <= ST_IDLE;
            last_dbus <= 1'b0;
            mem_stb_o <= 1'b0;
            mem_wre_o <= 1'b0;
            mem_sel_o <= '0;
            mem_adr_o <= '0;
            mem_dat_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_start) begin
                        mem_stb_o <= 1'b1;
                        last_dbus <= pick_dbus;
                        if (pick_dbus) begin
                            state     <= ST_DBUS;
                            mem_wre_o <= dwb_wre_i;
                            mem_sel_o <= dwb_sel_i;
                            mem_adr_o <= dwb_adr_i;
                            mem_dat_o <= dwb_dat_i;
                        end else begin
                            state     <= ST_IBUS;
                            mem_wre_o <= 1'b0;
                            mem_sel_o <= SEL_WORD;
                            mem_adr_o <= iwb_adr_i;
                            mem_dat_o <= '0;
                        end
                    end
                end
                // The mandatory IDLE bubble follows every completed or aborted grant.
                ST_IBUS, ST_DBUS: begin
                    if (xfer_done) begin
                        state     <= ST_IDLE;
                        mem_stb_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_stb_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aemb_wb_arbiter.sv
// tb/tb_aemb_wb_arbiter.sv - self-checking bench for aemb_wb_arbiter
module tb_aemb_wb_arbiter;

    localparam int AW    = 16;
    localparam int TMO   = 4;
    localparam int TW    = 8;
    localparam int ADR_W = AW - 2;

    logic              sys_clk_i;
    logic              sys_rst_i;
    logic              iwb_stb_i;
    logic [AW-1:2]     iwb_adr_i;
    logic              iwb_ack_o;
    logic [31:0]       iwb_dat_o;
    logic              dwb_stb_i;
    logic              dwb_wre_i;
    logic [3:0]        dwb_sel_i;
    logic [AW-1:2]     dwb_adr_i;
    logic [31:0]       dwb_dat_i;
    logic              dwb_ack_o;
    logic [31:0]       dwb_dat_o;
    logic              mem_stb_o;
    logic              mem_wre_o;
    logic [3:0]        mem_sel_o;
    logic [AW-1:2]     mem_adr_o;
    logic [31:0]       mem_dat_o;
    logic [31:0]       mem_dat_i;
    logic              mem_ack_i;
    logic              bus_err_o;
    logic              err_clr_i;

    aemb_wb_arbiter #(.AW(AW), .TMO(TMO), .TW(TW)) dut (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .iwb_stb_i (iwb_stb_i),
        .iwb_adr_i (iwb_adr_i),
        .iwb_ack_o (iwb_ack_o),
        .iwb_dat_o (iwb_dat_o),
        .dwb_stb_i (dwb_stb_i),
        .dwb_wre_i (dwb_wre_i),
        .dwb_sel_i (dwb_sel_i),
        .dwb_adr_i (dwb_adr_i),
        .dwb_dat_i (dwb_dat_i),
        .dwb_ack_o (dwb_ack_o),
        .dwb_dat_o (dwb_dat_o),
        .mem_stb_o (mem_stb_o),
        .mem_wre_o (mem_wre_o),
        .mem_sel_o (mem_sel_o),
        .mem_adr_o (mem_adr_o),
        .mem_dat_o (mem_dat_o),
        .mem_dat_i (mem_dat_i),
        .mem_ack_i (mem_ack_i),
        .bus_err_o (bus_err_o),
        .err_clr_i (err_clr_i)
    );

    initial begin
        sys_clk_i = 1'b0;
        forever #5 sys_clk_i = ~sys_clk_i;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge sys_clk_i);
        @(negedge sys_clk_i);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " mem_stb"}, mem_stb_o, 1'b0);
        chk({tag, " mem_wre"}, mem_wre_o, 1'b0);
        chk({tag, " iwb_ack"}, iwb_ack_o, 1'b0);
        chk({tag, " dwb_ack"}, dwb_ack_o, 1'b0);
        chk({tag, " bus_err"}, bus_err_o, 1'b0);
        chkw({tag, " mem_sel"}, 32'(mem_sel_o), 32'h0);
        chkw({tag, " mem_adr"}, 32'(mem_adr_o), 32'h0);
        chkw({tag, " mem_dat"}, mem_dat_o, 32'h0);
        chkw({tag, " iwb_dat"}, iwb_dat_o, 32'h0);
        chkw({tag, " dwb_dat"}, dwb_dat_o, 32'h0);
    endtask

    // gnt: 0 = bus idle, 1 = IWB owns the slave, 2 = DWB owns the slave
    typedef struct {
        logic        istb;
        logic        dstb;
        logic        dwre;
        logic [3:0]  dsel;
        logic        mack;
        logic [31:0] mdat;
        logic [1:0]  gnt;
        logic        iack;
        logic        dack;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int istb, input int dstb, input int dwre, input int dsel,
                           input int mack, input int mdat, input int gnt, input int iack, input int dack);
        vec_t v;
        v.istb = 1'(istb);
        v.dstb = 1'(dstb);
        v.dwre = 1'(dwre);
        v.dsel = 4'(dsel);
        v.mack = 1'(mack);
        v.mdat = 32'(mdat);
        v.gnt  = 2'(gnt);
        v.iack = 1'(iack);
        v.dack = 1'(dack);
        vecs.push_back(v);
    endtask

    int              m_owner, m_last, m_wait, pick;
    logic            m_err, m_tmo, m_wre;
    logic [ADR_W-1:0] m_adr;
    logic [3:0]      m_sel;
    logic [31:0]     m_dat, m_rd;

    initial begin
        iwb_stb_i = 1'b0; iwb_adr_i = '0;
        dwb_stb_i = 1'b0; dwb_wre_i = 1'b0; dwb_sel_i = '0; dwb_adr_i = '0; dwb_dat_i = '0;
        mem_ack_i = 1'b0; err_clr_i = 1'b0;
        mem_dat_i = 32'hCAFEF00D;
        sys_rst_i = 1'b0;
        repeat (2) @(negedge sys_clk_i);
        check_all_zero("reset");
        sys_rst_i = 1'b1;

        // Contention straight out of reset, then single read, then byte write.
        add_vec(1,1,0,15,0,0,          0,0,0);
        add_vec(1,1,0,15,1,'h0D0D0001, 2,0,1);
        add_vec(1,1,0,15,0,0,          0,0,0);
        add_vec(1,1,0,15,1,'h1A1A0002, 1,1,0);
        add_vec(1,1,0,15,0,0,          0,0,0);
        add_vec(1,1,0,15,1,'h0D0D0003, 2,0,1);
        add_vec(1,1,0,15,0,0,          0,0,0);
        add_vec(1,1,0,15,1,'h1A1A0004, 1,1,0);
        add_vec(0,0,0,15,0,0,          0,0,0);
        add_vec(1,0,0,15,0,0,          0,0,0);
        add_vec(1,0,0,15,0,0,          1,0,0);
        add_vec(1,0,0,15,0,0,          1,0,0);
        add_vec(1,0,0,15,1,'h600DF00D, 1,1,0);
        add_vec(0,0,0,15,0,0,          0,0,0);
        add_vec(0,1,1,2, 0,0,          0,0,0);
        add_vec(0,1,1,2, 0,0,          2,0,0);
        add_vec(0,1,1,2, 0,0,          2,0,0);
        add_vec(0,1,1,2, 1,'h55AA55AA, 2,0,1);
        add_vec(0,0,0,15,0,0,          0,0,0);

        iwb_adr_i = 14'h0010;
        dwb_adr_i = 14'h0040;
        dwb_dat_i = 32'h11223344;
        foreach (vecs[k]) begin
            iwb_stb_i = vecs[k].istb;
            dwb_stb_i = vecs[k].dstb;
            dwb_wre_i = vecs[k].dwre;
            dwb_sel_i = vecs[k].dsel;
            mem_ack_i = vecs[k].mack;
            mem_dat_i = vecs[k].mdat;
            #2;
            chk($sformatf("vec%0d mem_stb", k), mem_stb_o, vecs[k].gnt != 2'd0);
            chk($sformatf("vec%0d iwb_ack", k), iwb_ack_o, vecs[k].iack);
            chk($sformatf("vec%0d dwb_ack", k), dwb_ack_o, vecs[k].dack);
            chk($sformatf("vec%0d bus_err", k), bus_err_o, 1'b0);
            if (vecs[k].gnt == 2'd1) begin
                chkw($sformatf("vec%0d i adr", k), 32'(mem_adr_o), 32'h0010);
                chkw($sformatf("vec%0d i sel", k), 32'(mem_sel_o), 32'hF);
                chk($sformatf("vec%0d i wre", k), mem_wre_o, 1'b0);
            end
            if (vecs[k].gnt == 2'd2) begin
                chkw($sformatf("vec%0d d adr", k), 32'(mem_adr_o), 32'h0040);
                chkw($sformatf("vec%0d d sel", k), 32'(mem_sel_o), 32'(vecs[k].dsel));
                chk($sformatf("vec%0d d wre", k), mem_wre_o, vecs[k].dwre);
                chkw($sformatf("vec%0d d dat", k), mem_dat_o, 32'h11223344);
            end
            if (vecs[k].iack) chkw($sformatf("vec%0d iwb_dat", k), iwb_dat_o, vecs[k].mdat);
            if (vecs[k].dack) chkw($sformatf("vec%0d dwb_dat", k), dwb_dat_o, vecs[k].mdat);
            next_cycle();
        end

        // Timeout on a DWB read; err_clr on the same edge loses to the set.
        dwb_stb_i = 1'b1; dwb_wre_i = 1'b0; dwb_sel_i = 4'hF;
        mem_ack_i = 1'b0; mem_dat_i = 32'hDEADBEEF;
        #2;
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            err_clr_i = (c == 4);
            #2;
            chk($sformatf("tmo c%0d dwb_ack", c), dwb_ack_o, c == 4);
            chk($sformatf("tmo c%0d mem_stb", c), mem_stb_o, 1'b1);
            if (c == 4) chkw("tmo dwb_dat", dwb_dat_o, 32'h0);
            else        chk($sformatf("tmo c%0d bus_err", c), bus_err_o, 1'b0);
            next_cycle();
        end
        err_clr_i = 1'b0;
        dwb_stb_i = 1'b0;
        #2;
        chk("tmo bus_err set", bus_err_o, 1'b1);
        chk("tmo mem_stb low", mem_stb_o, 1'b0);
        next_cycle();

        // IWB withdraws its strobe mid-grant.
        iwb_stb_i = 1'b1;
        #2;
        next_cycle();
        iwb_stb_i = 1'b0;
        #2;
        chk("abort granted", mem_stb_o, 1'b1);
        chk("abort no ack 1", iwb_ack_o, 1'b0);
        next_cycle();
        #2;
        chk("abort mem_stb", mem_stb_o, 1'b0);
        chk("abort no ack 2", iwb_ack_o, 1'b0);
        chk("abort err kept", bus_err_o, 1'b1);

        err_clr_i = 1'b1;
        next_cycle();
        err_clr_i = 1'b0;
        #2;
        chk("err_clr", bus_err_o, 1'b0);
        next_cycle();

        // Acknowledge arriving in the last watchdog cycle wins.
        dwb_stb_i = 1'b1;
        #2;
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            mem_ack_i = (c == 4);
            #2;
            chk($sformatf("late ack c%0d dwb_ack", c), dwb_ack_o, c == 4);
            if (c == 4) chkw("late ack dwb_dat", dwb_dat_o, 32'hDEADBEEF);
            next_cycle();
        end
        dwb_stb_i = 1'b0; mem_ack_i = 1'b0;
        #2;
        chk("late ack no err", bus_err_o, 1'b0);
        chk("late ack idle", mem_stb_o, 1'b0);
        next_cycle();

        // Asynchronous reset in the middle of a DBUS write.
        dwb_stb_i = 1'b1; dwb_wre_i = 1'b1; dwb_sel_i = 4'h5; dwb_dat_i = 32'hA5A5A5A5;
        next_cycle();
        #2;
        chk("rst mid granted", mem_stb_o, 1'b1);
        mem_ack_i = 1'b1; mem_dat_i = 32'hFFFFFFFF;
        #1;
        sys_rst_i = 1'b0;
        #1;
        check_all_zero("rst mid");
        next_cycle();
        dwb_stb_i = 1'b0; dwb_wre_i = 1'b0; mem_ack_i = 1'b0;
        next_cycle();
        sys_rst_i = 1'b1;

        // Randomised traffic against a transaction-rule reference model.
        m_owner = 0; m_last = 1; m_wait = 0; m_err = 1'b0;
        m_adr = '0; m_sel = '0; m_wre = 1'b0; m_dat = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            iwb_stb_i = ($urandom % 4) != 0;
            dwb_stb_i = ($urandom % 4) != 0;
            iwb_adr_i = ADR_W'($urandom);
            dwb_adr_i = ADR_W'($urandom);
            dwb_wre_i = 1'($urandom);
            dwb_sel_i = 4'($urandom);
            dwb_dat_i = $urandom;
            mem_ack_i = ($urandom % 3) == 0;
            mem_dat_i = $urandom;
            err_clr_i = ($urandom % 16) == 0;
            #2;
            m_tmo = (m_owner != 0) && (m_wait == TMO - 1) && !mem_ack_i;
            m_rd  = m_tmo ? 32'h0 : mem_dat_i;
            chk($sformatf("rnd%0d mem_stb", cyc), mem_stb_o, m_owner != 0);
            chk($sformatf("rnd%0d iwb_ack", cyc), iwb_ack_o, (m_owner == 1) && (mem_ack_i || m_tmo));
            chk($sformatf("rnd%0d dwb_ack", cyc), dwb_ack_o, (m_owner == 2) && (mem_ack_i || m_tmo));
            chkw($sformatf("rnd%0d iwb_dat", cyc), iwb_dat_o, m_rd);
            chkw($sformatf("rnd%0d dwb_dat", cyc), dwb_dat_o, m_rd);
            chk($sformatf("rnd%0d bus_err", cyc), bus_err_o, m_err);
            if (m_owner != 0) begin
                chkw($sformatf("rnd%0d mem_adr", cyc), 32'(mem_adr_o), 32'(m_adr));
                chkw($sformatf("rnd%0d mem_sel", cyc), 32'(mem_sel_o), 32'(m_sel));
                chk($sformatf("rnd%0d mem_wre", cyc), mem_wre_o, m_wre);
            end
            if (m_owner == 2) chkw($sformatf("rnd%0d mem_dat", cyc), mem_dat_o, m_dat);

            if (m_owner == 0) begin
                if (iwb_stb_i && dwb_stb_i) pick = (m_last == 2) ? 1 : 2;
                else if (iwb_stb_i)         pick = 1;
                else if (dwb_stb_i)         pick = 2;
                else                        pick = 0;
                if (pick != 0) begin
                    m_owner = pick;
                    m_last  = pick;
                    m_wait  = 0;
                    m_adr   = (pick == 1) ? iwb_adr_i : dwb_adr_i;
                    m_sel   = (pick == 1) ? 4'hF : dwb_sel_i;
                    m_wre   = (pick == 2) && dwb_wre_i;
                    m_dat   = dwb_dat_i;
                end
            end else if (mem_ack_i || m_tmo || !((m_owner == 1) ? iwb_stb_i : dwb_stb_i)) begin
                m_owner = 0;
            end else begin
                m_wait++;
            end
            if (m_tmo)          m_err = 1'b1;
            else if (err_clr_i) m_err = 1'b0;
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
